// File: rtl/clk_ctrl_if.sv
// clk_ctrl_if: command inputs and clock-enable/status outputs of clk_ctrl
interface clk_ctrl_if;
  logic        run_req;
  logic        halt_req;
  logic        step_req;
  logic [1:0]  div_sel;
  logic        bkpt_hit;
  logic        cpu_en;
  logic        led_tick;
  logic [1:0]  state;
  logic        bkpt_flag;
  logic [31:0] cyc_cnt;
  modport master (
    output run_req, halt_req, step_req, div_sel, bkpt_hit,
    input  cpu_en, led_tick, state, bkpt_flag, cyc_cnt
  );
  modport slave (
    input  run_req, halt_req, step_req, div_sel, bkpt_hit,
    output cpu_en, led_tick, state, bkpt_flag, cyc_cnt
  );
endinterface

// File: rtl/clk_ctrl.sv
// clk_ctrl: run/halt/step CPU clock-enable generator with free-running display tick.
// Define CLK_CTRL_BKPT_EN to let bkpt_hit stop RUN and raise the sticky bkpt_flag.
module clk_ctrl #(
  parameter int unsigned DIV_N0 = 5000000,
  parameter int unsigned DIV_N1 = 500000,
  parameter int unsigned DIV_N2 = 50000,
  parameter int unsigned DIV_N3 = 2,
  parameter int unsigned LED_N  = 100000
) (
  input logic       clk_board,
  input logic       rst_n,
  clk_ctrl_if.slave bus
);
  typedef enum logic [1:0] {HALT = 2'b00, RUN = 2'b01, STEP = 2'b10} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_div_cnt, r_led_cnt, r_cyc, w_n;
  logic [1:0]  r_div_sel;
  logic        r_en, r_led, w_brk, w_clr, w_wrap, w_en, w_led_wrap;
`ifdef CLK_CTRL_BKPT_EN
  logic        r_bkpt;
  assign w_brk = bus.bkpt_hit;
`else
  logic        w_unused_bkpt;
  assign w_unused_bkpt = bus.bkpt_hit;
  assign w_brk = 1'b0;
`endif
  always_comb begin
    w_n = (r_div_sel == 2'd0) ? 32'(DIV_N0)
        : (r_div_sel == 2'd1) ? 32'(DIV_N1)
        : (r_div_sel == 2'd2) ? 32'(DIV_N2)
        : 32'(DIV_N3);
    w_next = (r_state == HALT) ? (bus.step_req ? STEP : bus.run_req ? RUN : HALT)
           : (r_state == RUN)  ? ((bus.halt_req || w_brk) ? HALT : RUN)
           : HALT;
    w_clr = (w_next == RUN && r_state != RUN) || (bus.div_sel != r_div_sel);
    w_wrap = r_div_cnt == w_n - 32'd1;
    // a wrap on the edge that leaves RUN (or restarts the count) must not pulse
    w_en = (r_state == STEP) || (r_state == RUN && w_next == RUN && w_wrap && !w_clr);
    w_led_wrap = r_led_cnt == 32'(LED_N - 1);
  end
  always_ff @(posedge clk_board or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= HALT;
      r_div_cnt <= '0;
      r_led_cnt <= '0;
      r_cyc     <= '0;
      r_div_sel <= '0;
      r_en      <= 1'b0;
      r_led     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_div_cnt <= w_clr ? '0 : (r_state == RUN) ? (w_wrap ? '0 : r_div_cnt + 32'd1) : r_div_cnt;
      r_led_cnt <= w_led_wrap ? '0 : r_led_cnt + 32'd1;
      r_cyc     <= r_cyc + {31'd0, w_en};
      r_div_sel <= bus.div_sel;
      r_en      <= w_en;
      r_led     <= w_led_wrap;
    end
  end
`ifdef CLK_CTRL_BKPT_EN
  always_ff @(posedge clk_board or negedge rst_n) begin
    if (!rst_n) r_bkpt <= 1'b0;
    else if (r_state == RUN && w_brk) r_bkpt <= 1'b1;
    else if (r_state == HALT && w_next != HALT) r_bkpt <= 1'b0;
  end
  assign bus.bkpt_flag = r_bkpt;
`else
  assign bus.bkpt_flag = 1'b0;
`endif
  assign bus.cpu_en   = r_en;
  assign bus.led_tick = r_led;
  assign bus.state    = r_state;
  assign bus.cyc_cnt  = r_cyc;
endmodule

// File: tb/tb_clk_ctrl.sv
// tb_clk_ctrl: directed stimulus pushes expected cpu_en pulses; a monitor pops and compares them
module tb_clk_ctrl;
  logic        clk_board = 1'b0;
  logic        rst_n = 1'b1;
  int          total = 0, bad = 0, cyc = 0, last_led = -1;
  int          q_cyc[$];
  logic [31:0] q_val[$];
  logic [31:0] exp_cnt = 0;
  clk_ctrl_if bus();
  clk_ctrl #(.DIV_N0(4), .DIV_N1(8), .DIV_N2(5), .DIV_N3(2), .LED_N(7)) dut (
    .clk_board(clk_board),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk_board = ~clk_board;
  always @(posedge clk_board) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic expect_pulse(input int c);
    exp_cnt = exp_cnt + 32'd1;
    q_cyc.push_back(c);
    q_val.push_back(exp_cnt);
  endtask
  task automatic cmd(input logic r, input logic h, input logic st, output int smp);
    bus.run_req = r;
    bus.halt_req = h;
    bus.step_req = st;
    @(negedge clk_board);
    bus.run_req = 1'b0;
    bus.halt_req = 1'b0;
    bus.step_req = 1'b0;
    smp = cyc;
  endtask
  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk_board);
  endtask
  task automatic preload_max();
    force dut.r_cyc = 32'hFFFF_FFFF;
    #1 release dut.r_cyc;
    exp_cnt = 32'hFFFF_FFFF;
  endtask
  initial begin
    forever begin
      @(negedge clk_board);
      if (bus.cpu_en) begin
        if (q_cyc.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected cpu_en: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          check("pulse cycle", 32'(cyc), 32'(q_cyc.pop_front()));
          check("pulse cyc_cnt", bus.cyc_cnt, q_val.pop_front());
        end
      end
      if (bus.led_tick && rst_n) begin
        if (last_led >= 0) check("led period", 32'(cyc - last_led), 32'd7);
        last_led = cyc;
      end
    end
  end
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int s, t;
    bus.run_req = 1'b0;
    bus.halt_req = 1'b0;
    bus.step_req = 1'b0;
    bus.div_sel = 2'd0;
    bus.bkpt_hit = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset state", bus.state, 0);
    check("reset cpu_en", bus.cpu_en, 0);
    check("reset led_tick", bus.led_tick, 0);
    check("reset bkpt_flag", bus.bkpt_flag, 0);
    check("reset cyc_cnt", bus.cyc_cnt, 0);
    repeat (2) @(negedge clk_board);
    rst_n = 1'b1;
    last_led = cyc;
    repeat (4) @(negedge clk_board);
    check("idle in halt", bus.state, 0);
    bus.div_sel = 2'd3;
    @(negedge clk_board);
    cmd(1, 0, 0, s);
    for (int k = 1; k <= 10; k++) expect_pulse(s + 2 * k);
    wait_to(s + 21);
    check("cyc_cnt after 10", bus.cyc_cnt, 10);
    check("state run", bus.state, 1);
    cmd(0, 1, 0, t);
    check("halt on wrap edge", bus.state, 0);
    repeat (4) @(negedge clk_board);
    cmd(0, 0, 1, s);
    check("step state", bus.state, 2);
    check("step no early en", bus.cpu_en, 0);
    expect_pulse(s + 1);
    @(negedge clk_board);
    check("step returns halt", bus.state, 0);
    check("step cyc_cnt", bus.cyc_cnt, 11);
    repeat (2) @(negedge clk_board);
    cmd(1, 0, 1, s);
    check("step beats run", bus.state, 2);
    expect_pulse(s + 1);
    @(negedge clk_board);
    check("step2 halt", bus.state, 0);
    repeat (2) @(negedge clk_board);
    cmd(1, 0, 0, s);
    expect_pulse(s + 2);
    expect_pulse(s + 4);
    wait_to(s + 5);
    cmd(1, 1, 1, t);
    check("all cmds in run", bus.state, 0);
    repeat (3) @(negedge clk_board);
    bus.div_sel = 2'd1;
    @(negedge clk_board);
    cmd(1, 0, 0, s);
    expect_pulse(s + 8);
    wait_to(s + 10);
    bus.div_sel = 2'd3;
    expect_pulse(s + 13);
    wait_to(s + 14);
    cmd(0, 1, 0, t);
    check("halt after div change", bus.state, 0);
    repeat (3) @(negedge clk_board);
    cmd(1, 0, 0, s);
    expect_pulse(s + 2);
`ifndef CLK_CTRL_BKPT_EN
    expect_pulse(s + 4);
    expect_pulse(s + 6);
`endif
    wait_to(s + 3);
    bus.bkpt_hit = 1'b1;
    @(negedge clk_board);
    bus.bkpt_hit = 1'b0;
`ifdef CLK_CTRL_BKPT_EN
    check("bkpt halts", bus.state, 0);
    check("bkpt flag set", bus.bkpt_flag, 1);
    repeat (2) @(negedge clk_board);
    check("bkpt flag sticky", bus.bkpt_flag, 1);
    cmd(1, 0, 0, t);
    check("run clears flag", bus.bkpt_flag, 0);
    check("rerun state", bus.state, 1);
    cmd(0, 1, 0, t);
    check("halt after rerun", bus.state, 0);
`else
    check("bkpt ignored", bus.state, 1);
    check("bkpt flag tied", bus.bkpt_flag, 0);
    wait_to(s + 6);
    cmd(0, 1, 0, t);
    check("halt after bkpt", bus.state, 0);
`endif
    repeat (3) @(negedge clk_board);
    cmd(1, 0, 0, s);
    preload_max();
    check("preload", bus.cyc_cnt, 32'hFFFF_FFFF);
    expect_pulse(s + 2);
    wait_to(s + 2);
    check("cyc_cnt wraps", bus.cyc_cnt, 0);
    wait_to(s + 3);
    preload_max();
    expect_pulse(s + 4);
    wait_to(s + 4);
    #2 rst_n = 1'b0;
    #1;
    check("async rst cpu_en", bus.cpu_en, 0);
    check("async rst state", bus.state, 0);
    check("async rst cyc_cnt", bus.cyc_cnt, 0);
    check("async rst led_tick", bus.led_tick, 0);
    check("async rst bkpt_flag", bus.bkpt_flag, 0);
    exp_cnt = 0;
    @(negedge clk_board);
    rst_n = 1'b1;
    last_led = cyc;
    repeat (10) @(negedge clk_board);
    check("halt after reset", bus.state, 0);
    check("cyc_cnt after reset", bus.cyc_cnt, 0);
    check("queue drained", 32'(q_cyc.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
